// File: rtl/sdram_bist_pkg.sv
// Shared types and the data pattern for the SDRAM BIST agent.
// The pattern is defined on a 20-bit address; callers cast wider or narrower addresses to 20 bits first.
package sdram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [15:0] DEFAULT_SEED = 16'hA5C3;

    function automatic logic [15:0] pat(input logic [19:0] a, input logic [15:0] seed);
        return a[15:0] ^ {12'h0, a[19:16]} ^ seed;
    endfunction

endpackage

// File: rtl/sdram_bist_checker.sv
// Read-data checker: walks its own expected address and compares returned words to the pattern.
// It counts mismatches (saturating) and keeps the address of the first mismatch of a run.
module sdram_bist_checker
    import sdram_bist_pkg::*;
#(
    parameter int                ADDR_W    = 20,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [15:0]       SEED      = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              active,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_valid,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    assign exp_data = DATA_W'(pat(20'(exp_addr), SEED));
    assign mismatch = active && rd_data_valid && (rd_data != exp_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_addr       <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (clear) begin
            exp_addr       <= BASE_ADDR;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            if (load) begin
                exp_addr <= BASE_ADDR;
            end else if (active && rd_data_valid) begin
                exp_addr <= exp_addr + 1'b1;
            end
            if (mismatch) begin
                // err_count cannot return to zero within a run, so zero marks the first mismatch
                if (err_count == '0) begin
                    first_err_addr <= exp_addr;
                end
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_bist_agent.sv
// SDRAM BIST agent: writes a pattern over an address window, reads it back, and measures phase cycles.
// Optional watchdog enabled by defining SDRAM_BIST_TIMEOUT_EN.
module sdram_bist_agent
    import sdram_bist_pkg::*;
#(
    parameter int                ADDR_W    = 20,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_WORDS = 256,
    parameter logic [15:0]       SEED      = DEFAULT_SEED,
    parameter int                TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [31:0]       wr_cycles,
    output logic [31:0]       rd_cycles,
    output logic              WrReq,
    input  logic              WrGnt,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData,
    output logic              RdReq,
    input  logic              RdGnt,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    input  logic              RdDataValid,
    output logic              timeout
);

    localparam int              CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  outstanding;
    logic              in_read;
    logic              rd_inc;
    logic              rd_dec;
    logic              clear;
    logic              load;

    assign addr_inc = addr + 1'b1;
    assign in_read  = (state == READ) || (state == DRAIN);
    assign rd_inc   = (state == READ) && RdGnt;
    // A stray strobe with nothing outstanding must not wrap the counter
    assign rd_dec   = in_read && RdDataValid && ((outstanding != '0) || rd_inc);
    assign clear    = (state == IDLE) && start;
    assign load     = (state == WRITE) && WrGnt && (cnt == LAST);
    assign WrAddr   = addr;
    assign RdAddr   = addr;

`ifdef SDRAM_BIST_TIMEOUT_EN
    logic [31:0] wd;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            wr_cycles   <= '0;
            rd_cycles   <= '0;
            WrReq       <= 1'b0;
            RdReq       <= 1'b0;
            WrData      <= '0;
            addr        <= '0;
            cnt         <= '0;
            outstanding <= '0;
`ifdef SDRAM_BIST_TIMEOUT_EN
            wd          <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        wr_cycles   <= '0;
                        rd_cycles   <= '0;
                        addr        <= BASE_ADDR;
                        WrData      <= DATA_W'(pat(20'(BASE_ADDR), SEED));
                        cnt         <= '0;
                        outstanding <= '0;
                        WrReq       <= 1'b1;
                        state       <= WRITE;
`ifdef SDRAM_BIST_TIMEOUT_EN
                        wd          <= '0;
                        timeout     <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    if (wr_cycles != '1) wr_cycles <= wr_cycles + 1'b1;
                    if (WrGnt) begin
                        if (cnt == LAST) begin
                            WrReq <= 1'b0;
                            RdReq <= 1'b1;
                            addr  <= BASE_ADDR;
                            cnt   <= '0;
                            state <= READ;
                        end else begin
                            addr   <= addr_inc;
                            WrData <= DATA_W'(pat(20'(addr_inc), SEED));
                            cnt    <= cnt + 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_cycles != '1) rd_cycles <= rd_cycles + 1'b1;
                    if (RdGnt) begin
                        addr <= addr_inc;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            RdReq <= 1'b0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_cycles != '1) rd_cycles <= rd_cycles + 1'b1;
                    if (outstanding == '0) state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0) && !timeout;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (in_read) begin
                outstanding <= outstanding + CNT_W'(rd_inc) - CNT_W'(rd_dec);
            end

`ifdef SDRAM_BIST_TIMEOUT_EN
            // Watchdog overrides the phase logic above when it fires
            if ((state == WRITE) || (state == READ) || (state == DRAIN)) begin
                if (WrGnt || RdGnt || RdDataValid) begin
                    wd <= '0;
                end else if (wd == 32'(TIMEOUT)) begin
                    timeout <= 1'b1;
                    WrReq   <= 1'b0;
                    RdReq   <= 1'b0;
                    state   <= DONE;
                end else begin
                    wd <= wd + 1'b1;
                end
            end
`endif
        end
    end

    sdram_bist_checker #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BASE_ADDR (BASE_ADDR),
        .SEED      (SEED)
    ) u_checker (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .load           (load),
        .active         (in_read),
        .rd_data        (RdData),
        .rd_data_valid  (RdDataValid),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_sdram_bist_agent.sv
// Bench for sdram_bist_agent: a memory/controller model with latency, grant denial and bit flips,
// plus a second instance exercising an address window that wraps past all-ones.
module tb_sdram_bist_agent;

    localparam int          AW   = 20;
    localparam int          DW   = 16;
    localparam int          NW   = 256;
    localparam logic [15:0] SEED = 16'hA5C3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic          busy, done, pass, WrReq, RdReq, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr, WrAddr, RdAddr;
    logic [31:0]   wr_cycles, rd_cycles;
    logic [DW-1:0] WrData, RdData;
    logic          WrGnt, RdGnt, RdDataValid;

    sdram_bist_agent #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR('0), .NUM_WORDS(NW),
                       .SEED(SEED), .TIMEOUT(1024)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .wr_cycles(wr_cycles), .rd_cycles(rd_cycles),
        .WrReq(WrReq), .WrGnt(WrGnt), .WrAddr(WrAddr), .WrData(WrData),
        .RdReq(RdReq), .RdGnt(RdGnt), .RdAddr(RdAddr), .RdData(RdData),
        .RdDataValid(RdDataValid), .timeout(timeout)
    );

    // Wrapping-window instance
    logic          w_start = 1'b0;
    logic          w_busy, w_done, w_pass, w_WrReq, w_RdReq, w_timeout;
    logic [15:0]   w_err_count;
    logic [AW-1:0] w_first_err_addr, w_WrAddr, w_RdAddr;
    logic [31:0]   w_wr_cycles, w_rd_cycles;
    logic [DW-1:0] w_WrData, w_RdData;
    logic          w_WrGnt, w_RdGnt, w_RdDataValid;

    sdram_bist_agent #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(20'hFFFFE), .NUM_WORDS(4),
                       .SEED(SEED), .TIMEOUT(1024)) u_wrap (
        .clk(clk), .rst(rst), .start(w_start), .busy(w_busy), .done(w_done), .pass(w_pass),
        .err_count(w_err_count), .first_err_addr(w_first_err_addr),
        .wr_cycles(w_wr_cycles), .rd_cycles(w_rd_cycles),
        .WrReq(w_WrReq), .WrGnt(w_WrGnt), .WrAddr(w_WrAddr), .WrData(w_WrData),
        .RdReq(w_RdReq), .RdGnt(w_RdGnt), .RdAddr(w_RdAddr), .RdData(w_RdData),
        .RdDataValid(w_RdDataValid), .timeout(w_timeout)
    );

    int checks = 0;
    int failures = 0;

    function automatic logic [15:0] ref_pat(input int unsigned a);
        int unsigned v;
        v = (a & 32'hFFFF) ^ ((a >> 16) & 32'hF) ^ 32'(SEED);
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- controller / memory model for u_dut ----------------
    logic [15:0]   mem [int];
    logic [AW-1:0] wr_log[$];
    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] pend_a[$];
    int            pend_due[$];
    int            cyc = 0;
    int            hold_err = 0, both_high = 0, wr_req_cyc = 0;
    bit            deny_mode = 0, flip_mode = 0, never_grant = 0;
    bit            held = 0, grant_ok;
    logic [AW-1:0] held_a, ra;
    logic [DW-1:0] held_d;

    initial begin
        WrGnt = 1'b0; RdGnt = 1'b0; RdDataValid = 1'b0; RdData = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                pend_a.delete();
                pend_due.delete();
                held = 0;
            end else begin
                if (WrReq && RdReq) both_high++;
                if (WrReq) begin
                    wr_req_cyc++;
                    if (held && (WrAddr !== held_a || WrData !== held_d)) hold_err++;
                    held = !WrGnt;
                    held_a = WrAddr;
                    held_d = WrData;
                    if (WrGnt) begin
                        mem[int'(WrAddr)] = WrData;
                        wr_log.push_back(WrAddr);
                    end
                end else begin
                    held = 0;
                end
                if (RdReq && RdGnt) begin
                    rd_log.push_back(RdAddr);
                    pend_a.push_back(RdAddr);
                    pend_due.push_back(cyc + 4);
                end
            end
            @(negedge clk);
            grant_ok = !never_grant && !(deny_mode && (cyc % 3 == 0));
            WrGnt = WrReq && grant_ok && !rst;
            RdGnt = RdReq && grant_ok && !rst;
            RdDataValid = 1'b0;
            if (!rst && pend_a.size() > 0 && pend_due[0] <= cyc) begin
                ra = pend_a.pop_front();
                void'(pend_due.pop_front());
                RdDataValid = 1'b1;
                RdData = mem.exists(int'(ra)) ? mem[int'(ra)] : 16'h0;
                if (flip_mode && (ra == 20'h00010 || ra == 20'h00020)) RdData = RdData ^ 16'h0001;
            end
        end
    end

    // ---------------- simple always-grant model for u_wrap ----------------
    logic [15:0]   mem2 [int];
    logic [AW-1:0] w_wlog[$];
    logic [AW-1:0] w_rlog[$];
    logic [AW-1:0] w_pend[$];
    logic [AW-1:0] wa;

    initial begin
        w_WrGnt = 1'b0; w_RdGnt = 1'b0; w_RdDataValid = 1'b0; w_RdData = '0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (w_WrReq && w_WrGnt) begin
                    mem2[int'(w_WrAddr)] = w_WrData;
                    w_wlog.push_back(w_WrAddr);
                end
                if (w_RdReq && w_RdGnt) begin
                    w_rlog.push_back(w_RdAddr);
                    w_pend.push_back(w_RdAddr);
                end
            end
            @(negedge clk);
            w_WrGnt = w_WrReq && !rst;
            w_RdGnt = w_RdReq && !rst;
            w_RdDataValid = 1'b0;
            if (!rst && w_pend.size() > 0) begin
                wa = w_pend.pop_front();
                w_RdDataValid = 1'b1;
                w_RdData = mem2.exists(int'(wa)) ? mem2[int'(wa)] : 16'h0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_log();
        wr_log.delete();
        rd_log.delete();
        hold_err = 0;
        both_high = 0;
        wr_req_cyc = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    task automatic check_log(input string tag);
        int bad_a = 0, bad_d = 0;
        check({tag, "_wr_words"}, wr_log.size(), NW);
        check({tag, "_rd_words"}, rd_log.size(), NW);
        foreach (wr_log[i]) if (wr_log[i] !== AW'(i)) bad_a++;
        foreach (rd_log[i]) if (rd_log[i] !== AW'(i)) bad_a++;
        for (int i = 0; i < NW; i++) begin
            if (!mem.exists(i) || mem[i] !== ref_pat(i)) bad_d++;
        end
        check({tag, "_addr_seq"}, bad_a, 0);
        check({tag, "_mem_data"}, bad_d, 0);
        check({tag, "_both_req"}, both_high, 0);
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_req", {WrReq, RdReq}, 0);
        check("rst_cycles", {wr_cycles, rd_cycles}, 0);
        check("rst_timeout", timeout, 0);

        // Start coinciding with reset is lost
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        check("start_in_rst_busy", busy, 0);
        check("start_in_rst_wrreq", WrReq, 0);

        // Ideal controller
        clear_log();
        pulse_start();
        wait_done("ideal", 2000);
        check_log("ideal");
        check("ideal_pass", pass, 1);
        check("ideal_err", err_count, 0);
        check("ideal_busy", busy, 0);
        check("ideal_wr_cycles", wr_cycles, NW);
        check("ideal_rd_cycles", rd_cycles, NW + 5 + 1);

        // Grant denied every third cycle
        deny_mode = 1;
        mem.delete();
        clear_log();
        pulse_start();
        wait_done("deny", 3000);
        check_log("deny");
        check("deny_hold", hold_err, 0);
        check("deny_pass", pass, 1);
        check("deny_wr_cycles", wr_cycles, wr_req_cyc);
        deny_mode = 0;

        // Bit flips on read-back
        flip_mode = 1;
        clear_log();
        pulse_start();
        wait_done("flip", 2000);
        check("flip_err", err_count, 2);
        check("flip_first", first_err_addr, 20'h00010);
        check("flip_pass", pass, 0);
        flip_mode = 0;

        // Reset in the middle of the read phase, then a clean rerun
        clear_log();
        pulse_start();
        begin
            int n = 0;
            while (rd_log.size() < 100 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("midrst_reached", rd_log.size() >= 100, 1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_rdreq", RdReq, 0);
        check("midrst_wrreq", WrReq, 0);
        check("midrst_flags", {busy, done, pass}, 0);
        check("midrst_counts", {err_count, first_err_addr, wr_cycles, rd_cycles}, 0);
        check("midrst_bus", {WrAddr, WrData, RdAddr}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        clear_log();
        pulse_start();
        wait_done("rerun", 2000);
        check_log("rerun");
        check("rerun_pass", pass, 1);

        // Wrapping window on the second instance
        @(negedge clk); w_start = 1'b1;
        @(negedge clk); w_start = 1'b0;
        begin
            int n = 0;
            int bad = 0;
            int unsigned ea;
            while (w_done !== 1'b1 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check("wrap_done", w_done, 1);
            check("wrap_pass", w_pass, 1);
            check("wrap_wr_words", w_wlog.size(), 4);
            check("wrap_rd_words", w_rlog.size(), 4);
            for (int i = 0; i < 4; i++) begin
                ea = (32'hFFFFE + i) % 32'h100000;
                if (i < w_wlog.size() && w_wlog[i] !== ea[AW-1:0]) bad++;
                if (i < w_rlog.size() && w_rlog[i] !== ea[AW-1:0]) bad++;
                if (!mem2.exists(int'(ea)) || mem2[int'(ea)] !== ref_pat(ea)) bad++;
            end
            check("wrap_seq", bad, 0);
        end

        // Controller that never grants
        never_grant = 1;
        clear_log();
        pulse_start();
        repeat (1100) @(posedge clk);
        #1;
`ifdef SDRAM_BIST_TIMEOUT_EN
        check("wd_timeout", timeout, 1);
        check("wd_done", done, 1);
        check("wd_pass", pass, 0);
        check("wd_busy", busy, 0);
`else
        check("nowd_busy", busy, 1);
        check("nowd_done", done, 0);
        check("nowd_timeout", timeout, 0);
`endif
        check("nogrant_wrreq_cycles", wr_req_cyc >= 1000, 1);
        never_grant = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("final_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
